// File: rtl/vga_timing_gen_if.sv
// vga_if: pixel-stream bundle passed between the timing generator and the
// draw_* overlay stages.
//   hcount[10:0] / vcount[10:0] : pixel position of the current beat
//   hsync / vsync               : sync pulses, active-high on this bundle
//   hblnk / vblnk               : blanking flags for the current beat
//   rgb[11:0]                   : 4:4:4 colour of the current beat
// Modports:
//   vga_out : driven side (source of the stream)
//   vga_in  : consuming side (next draw stage)
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport vga_in (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: head of the draw pipeline. Produces the 1024x768@60 raster
// (65 MHz pixel clock) as a vga_if stream plus a per-frame pulse and a
// free-running frame counter for game logic / animation.
//
// Ports:
//   clk         : pixel clock
//   rst         : synchronous reset, active-high
//   vga_out     : vga_if.vga_out stream (hcount, vcount, hsync, vsync,
//                 hblnk, vblnk, rgb), every signal registered
//   frame_start : one-beat pulse on the (0,0) beat that follows a vertical
//                 wrap (not on the (0,0) beat presented by reset)
//   frame_cnt   : completed frames, modulo 2^16
//
// Optional build macro: VGA_TIMING_TEST_PATTERN_EN
//   defined   -> rgb shows 8 vertical colour bars across the active area
//   undefined -> rgb is constant 12'h000; timing outputs are identical
module vga_timing_gen #(
    parameter int HACTIVE     = 1024,
    parameter int HSYNC_START = 1048,
    parameter int HSYNC_W     = 136,
    parameter int HTOTAL      = 1344,
    parameter int VACTIVE     = 768,
    parameter int VSYNC_START = 771,
    parameter int VSYNC_W     = 6,
    parameter int VTOTAL      = 806
) (
    input  logic          clk,
    input  logic          rst,
    vga_if.vga_out        vga_out,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    // The counters are 11 bits wide, so the raster must fit in 2048x2048.
    generate
        if ((HTOTAL > 2048) || (VTOTAL > 2048) || (HACTIVE < 8)) begin : g_bad_params
            $error("vga_timing_gen: HTOTAL/VTOTAL must be <= 2048 and HACTIVE >= 8");
        end
    endgenerate

    // Decode thresholds are kept 12 bits wide so that an end-of-sync bound of
    // exactly 2048 still compares correctly against an 11-bit counter.
    localparam logic [10:0] H_LAST      = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(VTOTAL - 1);
    localparam logic [11:0] H_ACT       = 12'(HACTIVE);
    localparam logic [11:0] H_SYNC_BEG  = 12'(HSYNC_START);
    localparam logic [11:0] H_SYNC_END  = 12'(HSYNC_START + HSYNC_W);
    localparam logic [11:0] V_ACT       = 12'(VACTIVE);
    localparam logic [11:0] V_SYNC_BEG  = 12'(VSYNC_START);
    localparam logic [11:0] V_SYNC_END  = 12'(VSYNC_START + VSYNC_W);

    logic [10:0] hcount_r;
    logic [10:0] vcount_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        hblnk_r;
    logic        vblnk_r;
    logic [11:0] rgb_r;

    logic [10:0] hcount_nxt_s;
    logic [10:0] vcount_nxt_s;
    logic        frame_wrap_s;
    logic [11:0] h_ext_s;
    logic [11:0] v_ext_s;
    logic        hsync_nxt_s;
    logic        vsync_nxt_s;
    logic        hblnk_nxt_s;
    logic        vblnk_nxt_s;
    logic [11:0] rgb_nxt_s;

    // Next raster position: advance one pixel, wrap line, wrap frame.
    always_comb begin
        hcount_nxt_s = hcount_r + 11'd1;
        vcount_nxt_s = vcount_r;
        frame_wrap_s = 1'b0;
        if (hcount_r == H_LAST) begin
            hcount_nxt_s = 11'd0;
            if (vcount_r == V_LAST) begin
                vcount_nxt_s = 11'd0;
                frame_wrap_s = 1'b1;
            end else begin
                vcount_nxt_s = vcount_r + 11'd1;
            end
        end else begin
            hcount_nxt_s = hcount_r + 11'd1;
        end
    end

    // Flags are decoded from the next position so they land in the same
    // register stage as the counters they describe (zero skew).
    always_comb begin
        h_ext_s     = {1'b0, hcount_nxt_s};
        v_ext_s     = {1'b0, vcount_nxt_s};
        hblnk_nxt_s = (h_ext_s >= H_ACT);
        vblnk_nxt_s = (v_ext_s >= V_ACT);
        hsync_nxt_s = (h_ext_s >= H_SYNC_BEG) && (h_ext_s < H_SYNC_END);
        vsync_nxt_s = (v_ext_s >= V_SYNC_BEG) && (v_ext_s < V_SYNC_END);
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = HACTIVE / 8;

    logic [2:0] bar_idx_s;

    // Colour bars: eight equal-width bars across the active area, black in blanking.
    always_comb begin
        bar_idx_s = 3'(hcount_nxt_s / 11'(BAR_W));
        rgb_nxt_s = 12'h000;
        if (hblnk_nxt_s || vblnk_nxt_s) begin
            rgb_nxt_s = 12'h000;
        end else begin
            case (bar_idx_s)
                3'd0:    rgb_nxt_s = 12'hFFF;
                3'd1:    rgb_nxt_s = 12'hFF0;
                3'd2:    rgb_nxt_s = 12'h0FF;
                3'd3:    rgb_nxt_s = 12'h0F0;
                3'd4:    rgb_nxt_s = 12'hF0F;
                3'd5:    rgb_nxt_s = 12'hF00;
                3'd6:    rgb_nxt_s = 12'h00F;
                3'd7:    rgb_nxt_s = 12'h000;
                default: rgb_nxt_s = 12'h000;
            endcase
        end
    end
`else
    // Background is left to the downstream draw stages.
    assign rgb_nxt_s = 12'h000;
`endif

    // Stream register: counters, decoded flags, colour and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_r    <= 11'd0;
            vcount_r    <= 11'd0;
            hsync_r     <= 1'b0;
            vsync_r     <= 1'b0;
            hblnk_r     <= 1'b0;
            vblnk_r     <= 1'b0;
            rgb_r       <= 12'h000;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            hcount_r    <= hcount_nxt_s;
            vcount_r    <= vcount_nxt_s;
            hsync_r     <= hsync_nxt_s;
            vsync_r     <= vsync_nxt_s;
            hblnk_r     <= hblnk_nxt_s;
            vblnk_r     <= vblnk_nxt_s;
            rgb_r       <= rgb_nxt_s;
            // Only a genuine vertical wrap marks a frame; the reset (0,0) beat does not.
            frame_start <= frame_wrap_s;
            if (frame_wrap_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

    assign vga_out.hcount = hcount_r;
    assign vga_out.vcount = vcount_r;
    assign vga_out.hsync  = hsync_r;
    assign vga_out.vsync  = vsync_r;
    assign vga_out.hblnk  = hblnk_r;
    assign vga_out.vblnk  = vblnk_r;
    assign vga_out.rgb    = rgb_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Two instances run side by side:
//   dut_full  : the real 1024x768 timing, for line-level checks and bars
//   dut_small : a scaled 24x12 raster so frame wraps, vertical decode and
//               the frame counter are reachable in a short run
// Each beat a reference model pushes the expected stream beat into a queue
// per instance; after the clock edge the beat is popped and compared.
// Directed checks against fixed constants are interleaved.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        fs;
        logic [15:0] fc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_full = 1'b1;
    logic        rst_small = 1'b1;
    logic        fs_full;
    logic        fs_small;
    logic [15:0] fc_full;
    logic [15:0] fc_small;

    int checks = 0;
    int failures = 0;

    beat_t m_full  = '0;
    beat_t m_small = '0;
    beat_t q_full [$];
    beat_t q_small [$];

    logic [11:0] bar_rgb [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_if vga_full ();
    vga_if vga_small ();

    vga_timing_gen dut_full (
        .clk         (clk),
        .rst         (rst_full),
        .vga_out     (vga_full),
        .frame_start (fs_full),
        .frame_cnt   (fc_full)
    );

    vga_timing_gen #(
        .HACTIVE     (16),
        .HSYNC_START (18),
        .HSYNC_W     (4),
        .HTOTAL      (24),
        .VACTIVE     (8),
        .VSYNC_START (9),
        .VSYNC_W     (2),
        .VTOTAL      (12)
    ) dut_small (
        .clk         (clk),
        .rst         (rst_small),
        .vga_out     (vga_small),
        .frame_start (fs_small),
        .frame_cnt   (fc_small)
    );

    always #5 clk = ~clk;

    function automatic beat_t model_next(beat_t cur, logic r, int hact, int hss, int hsw,
                                         int htot, int vact, int vss, int vsw, int vtot);
        beat_t n;
        int    hi;
        int    vi;
        n = '0;
        if (r) begin
            n = '0;
        end else begin
            hi   = int'(cur.h);
            vi   = int'(cur.v);
            n.fc = cur.fc;
            n.fs = 1'b0;
            if (hi == htot - 1) begin
                hi = 0;
                if (vi == vtot - 1) begin
                    vi   = 0;
                    n.fs = 1'b1;
                    n.fc = cur.fc + 16'd1;
                end else begin
                    vi = vi + 1;
                end
            end else begin
                hi = hi + 1;
            end
            n.h  = 11'(hi);
            n.v  = 11'(vi);
            n.hb = (hi >= hact);
            n.vb = (vi >= vact);
            n.hs = (hi >= hss) && (hi < hss + hsw);
            n.vs = (vi >= vss) && (vi < vss + vsw);
            if (PAT_EN && !(n.hb || n.vb)) begin
                n.rgb = bar_rgb[hi / (hact / 8)];
            end else begin
                n.rgb = 12'h000;
            end
        end
        return n;
    endfunction

    function automatic string fmt(beat_t b);
        return $sformatf("(h=%0d v=%0d hs=%0b vs=%0b hb=%0b vb=%0b rgb=%h fs=%0b fc=%0d)",
                         b.h, b.v, b.hs, b.vs, b.hb, b.vb, b.rgb, b.fs, b.fc);
    endfunction

    function automatic beat_t obs_full();
        beat_t b;
        b = {vga_full.hcount, vga_full.vcount, vga_full.hsync, vga_full.vsync,
             vga_full.hblnk, vga_full.vblnk, vga_full.rgb, fs_full, fc_full};
        return b;
    endfunction

    function automatic beat_t obs_small();
        beat_t b;
        b = {vga_small.hcount, vga_small.vcount, vga_small.hsync, vga_small.vsync,
             vga_small.hblnk, vga_small.vblnk, vga_small.rgb, fs_small, fc_small};
        return b;
    endfunction

    task automatic check_beat(string tag, beat_t obs, beat_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%s expected=%s", tag, fmt(obs), fmt(exp));
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: push expectations, clock, pop and compare both streams.
    task automatic tick();
        beat_t e;
        m_full  = model_next(m_full, rst_full, 1024, 1048, 136, 1344, 768, 771, 6, 806);
        m_small = model_next(m_small, rst_small, 16, 18, 4, 24, 8, 9, 2, 12);
        q_full.push_back(m_full);
        q_small.push_back(m_small);
        @(posedge clk);
        #1;
        e = q_full.pop_front();
        check_beat("beat_full", obs_full(), e);
        e = q_small.pop_front();
        check_beat("beat_small", obs_small(), e);
    endtask

    task automatic run_full_to(int h, int v, int budget);
        int n = 0;
        while (!((int'(vga_full.hcount) == h) && (int'(vga_full.vcount) == v)) && (n < budget)) begin
            tick();
            n++;
        end
        check($sformatf("reach_full_%0d_%0d", h, v),
              {5'd0, vga_full.hcount, 5'd0, vga_full.vcount}, {5'd0, 11'(h), 5'd0, 11'(v)});
    endtask

    task automatic run_small_to(int h, int v, int budget);
        int n = 0;
        while (!((int'(vga_small.hcount) == h) && (int'(vga_small.vcount) == v)) && (n < budget)) begin
            tick();
            n++;
        end
        check($sformatf("reach_small_%0d_%0d", h, v),
              {5'd0, vga_small.hcount, 5'd0, vga_small.vcount}, {5'd0, 11'(h), 5'd0, 11'(v)});
    endtask

    task automatic measure_frame(string tag, logic [15:0] exp_fc);
        int n = 0;
        tick();
        n++;
        check({tag, "_fs_drop"}, 32'(fs_small), 32'd0);
        while ((fs_small !== 1'b1) && (n < 1000)) begin
            tick();
            n++;
        end
        check({tag, "_period"}, 32'(n), 32'd288);
        check({tag, "_cnt"}, 32'(fc_small), 32'(exp_fc));
    endtask

    initial begin
        int hs_cnt;

        // Reset held for five cycles: everything zero.
        repeat (5) tick();
        check("rst_hcount", 32'(vga_full.hcount), 32'd0);
        check("rst_vcount", 32'(vga_full.vcount), 32'd0);
        check("rst_flags", {28'd0, vga_full.hsync, vga_full.vsync, vga_full.hblnk, vga_full.vblnk}, 32'd0);
        check("rst_rgb", 32'(vga_full.rgb), 32'd0);
        check("rst_frame", {15'd0, fs_full, fc_full}, 32'd0);

        // Release: the (0,0) beat stays, then the stream advances.
        rst_full = 1'b0;
        check("rel_first_h", 32'(vga_full.hcount), 32'd0);
        check("rel_first_fs", 32'(fs_full), 32'd0);
        tick();
        check("rel_next_h", 32'(vga_full.hcount), 32'd1);

        // Line 0 horizontal decode.
        run_full_to(1023, 0, 2000);
        check("hblnk_1023", 32'(vga_full.hblnk), 32'd0);
        tick();
        check("hblnk_1024", 32'(vga_full.hblnk), 32'd1);
        run_full_to(1047, 0, 100);
        check("hsync_1047", 32'(vga_full.hsync), 32'd0);
        tick();
        hs_cnt = 0;
        for (int i = 0; i < 136; i++) begin
            hs_cnt += int'(vga_full.hsync);
            tick();
        end
        check("hsync_width", 32'(hs_cnt), 32'd136);
        check("hsync_end_h", 32'(vga_full.hcount), 32'd1184);
        check("hsync_1184", 32'(vga_full.hsync), 32'd0);

        // Colour bars (all black when the pattern is compiled out).
        run_full_to(0, 5, 8000);
        check("rgb_h0", 32'(vga_full.rgb), PAT_EN ? 32'hFFF : 32'h000);
        run_full_to(130, 5, 200);
        check("rgb_h130", 32'(vga_full.rgb), PAT_EN ? 32'hFF0 : 32'h000);
        run_full_to(1023, 5, 1000);
        check("rgb_h1023", 32'(vga_full.rgb), 32'h000);

        // Horizontal wrap increments the line.
        run_full_to(1343, 10, 8000);
        tick();
        check("hwrap_h", 32'(vga_full.hcount), 32'd0);
        check("hwrap_v", 32'(vga_full.vcount), 32'd11);

        // Small raster: release and walk the vertical decode.
        rst_small = 1'b0;
        check("s_rel_h", 32'(vga_small.hcount), 32'd0);
        check("s_rel_fs", 32'(fs_small), 32'd0);
        run_small_to(0, 7, 400);
        check("vblnk_7", 32'(vga_small.vblnk), 32'd0);
        run_small_to(0, 8, 100);
        check("vblnk_8", 32'(vga_small.vblnk), 32'd1);
        check("vsync_8", 32'(vga_small.vsync), 32'd0);
        run_small_to(0, 9, 100);
        check("vsync_9", 32'(vga_small.vsync), 32'd1);
        check("rgb_vblank", 32'(vga_small.rgb), 32'h000);
        run_small_to(0, 10, 100);
        check("vsync_10", 32'(vga_small.vsync), 32'd1);
        run_small_to(0, 11, 100);
        check("vsync_11", 32'(vga_small.vsync), 32'd0);

        // Vertical wrap, frame pulse and counter.
        run_small_to(23, 11, 100);
        check("pre_wrap_fs", 32'(fs_small), 32'd0);
        check("pre_wrap_fc", 32'(fc_small), 32'd0);
        tick();
        check("wrap_pos", {5'd0, vga_small.hcount, 5'd0, vga_small.vcount}, 32'd0);
        check("wrap_fs", 32'(fs_small), 32'd1);
        check("wrap_fc", 32'(fc_small), 32'd1);
        measure_frame("frame2", 16'd2);
        measure_frame("frame3", 16'd3);

        // Mid-frame reset on the small raster.
        run_small_to(5, 6, 400);
        rst_small = 1'b1;
        tick();
        rst_small = 1'b0;
        check("mrst_s_pos", {5'd0, vga_small.hcount, 5'd0, vga_small.vcount}, 32'd0);
        check("mrst_s_flags", {28'd0, vga_small.hsync, vga_small.vsync, vga_small.hblnk, vga_small.vblnk}, 32'd0);
        check("mrst_s_fc", 32'(fc_small), 32'd0);
        run_small_to(23, 11, 400);
        tick();
        check("mrst_s_resume_fs", 32'(fs_small), 32'd1);
        check("mrst_s_resume_fc", 32'(fc_small), 32'd1);

        // Mid-frame reset on the full raster.
        run_full_to(500, 13, 5000);
        rst_full = 1'b1;
        tick();
        rst_full = 1'b0;
        check("mrst_f_pos", {5'd0, vga_full.hcount, 5'd0, vga_full.vcount}, 32'd0);
        check("mrst_f_flags", {28'd0, vga_full.hsync, vga_full.vsync, vga_full.hblnk, vga_full.vblnk}, 32'd0);
        check("mrst_f_fc", {15'd0, fs_full, fc_full}, 32'd0);
        tick();
        check("mrst_f_next_h", 32'(vga_full.hcount), 32'd1);
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
